// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- request/status bundle between the fetch control logic
// (master) and the program-counter stage (slave).
//   requests : stall, branch_en/branch_offset, jump_en/jump_target, call_en,
//              ret_en, irq
//   status   : pc, pc_next, irq_ack, ras_empty, ras_full, ras_overflow,
//              ras_underflow
interface pc_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic             branch_en;
   logic [WIDTH-1:0] branch_offset;
   logic             jump_en;
   logic [WIDTH-1:0] jump_target;
   logic             call_en;
   logic             ret_en;
   logic             irq;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_next;
   logic             irq_ack;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_overflow;
   logic             ras_underflow;

   modport master (
      output stall, branch_en, branch_offset, jump_en, jump_target,
             call_en, ret_en, irq,
      input  pc, pc_next, irq_ack, ras_empty, ras_full, ras_overflow,
             ras_underflow
   );

   modport slave (
      input  stall, branch_en, branch_offset, jump_en, jump_target,
             call_en, ret_en, irq,
      output pc, pc_next, irq_ack, ras_empty, ras_full, ras_overflow,
             ras_underflow
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- registered program counter for the instruction-fetch path.
// Next PC is chosen from stall / irq / return / jump(+call) / branch / step,
// in that priority. Calls and interrupts push onto a small circular
// return-address stack; returns pop it.
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : pc_sequencer_if slave (requests in, pc and RAS status out)
module pc_sequencer #(
   parameter int WIDTH        = 32,
   parameter int STEP         = 1,
   parameter int RESET_VECTOR = 0,
   parameter int IRQ_VECTOR   = 16,
   parameter int RAS_DEPTH    = 4
) (
   input  logic           clock,
   input  logic           reset_n,
   pc_sequencer_if.slave  bus
);

   localparam int               PW      = $clog2(RAS_DEPTH);
   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VECTOR);
   localparam logic [WIDTH-1:0] IRQ_W   = WIDTH'(IRQ_VECTOR);
   localparam logic [PW:0]      DEPTH_C = (PW+1)'(RAS_DEPTH);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pc_seq;
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]    top_q;
   logic [PW-1:0]    top_inc;
   logic [PW:0]      count_q;
   logic             ras_full_w;
   logic             ras_empty_w;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] push_val;
   logic             irq_take;
   logic             uf_set;
   logic             ov_q;
   logic             uf_q;
   logic             ack_q;

   assign pc_seq      = pc_q + STEP_W;
   assign top_inc     = top_q + 1'b1;
   assign ras_empty_w = (count_q == '0);
   assign ras_full_w  = (count_q == DEPTH_C);

   always_comb begin
      pc_d     = pc_seq;
      push     = 1'b0;
      pop      = 1'b0;
      push_val = pc_seq;
      irq_take = 1'b0;
      uf_set   = 1'b0;
      if (bus.stall) begin
         pc_d = pc_q;
      end else if (bus.irq) begin
         // the interrupted instruction has not executed yet, so resume at pc
         pc_d     = IRQ_W;
         push     = 1'b1;
         push_val = pc_q;
         irq_take = 1'b1;
      end else if (bus.ret_en) begin
         if (!ras_empty_w) begin
            pc_d = ras_mem[top_q];
            pop  = 1'b1;
         end else begin
            uf_set = 1'b1;
         end
      end else if (bus.jump_en) begin
         pc_d = bus.jump_target;
         push = bus.call_en;
      end else if (bus.branch_en) begin
         pc_d = pc_seq + bus.branch_offset;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q    <= RESET_W;
         top_q   <= '0;
         count_q <= '0;
         ov_q    <= 1'b0;
         uf_q    <= 1'b0;
         ack_q   <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_mem[i] <= '0;
         end
      end else begin
         pc_q  <= pc_d;
         ack_q <= irq_take;
         if (uf_set) begin
            uf_q <= 1'b1;
         end
         if (push) begin
            // when full, the slot after top holds the oldest entry, so the
            // pointer advance itself discards it
            ras_mem[top_inc] <= push_val;
            top_q            <= top_inc;
            if (ras_full_w) begin
               ov_q <= 1'b1;
            end else begin
               count_q <= count_q + 1'b1;
            end
         end else if (pop) begin
            top_q   <= top_q - 1'b1;
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_next       = pc_d;
   assign bus.irq_ack       = ack_q;
   assign bus.ras_empty     = ras_empty_w;
   assign bus.ras_full      = ras_full_w;
   assign bus.ras_overflow  = ov_q;
   assign bus.ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;

   pc_sequencer_if #(.WIDTH(32)) bus ();

   pc_sequencer dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        s, i, r, j, c, b;
      logic [31:0] off;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
      logic        e, f, ov, uf, ack;
   } vec_t;

   vec_t vt [30];

   function automatic vec_t mk(input logic s, i, r, j, c, b,
                               input logic [31:0] off, tgt, exp_pc,
                               input logic e, f, ov, uf, ack);
      vec_t v;
      v.s = s; v.i = i; v.r = r; v.j = j; v.c = c; v.b = b;
      v.off = off; v.tgt = tgt; v.exp_pc = exp_pc;
      v.e = e; v.f = f; v.ov = ov; v.uf = uf; v.ack = ack;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, i, r, j, c, b, input logic [31:0] off, tgt);
      bus.stall         = s;
      bus.irq           = i;
      bus.ret_en        = r;
      bus.jump_en       = j;
      bus.call_en       = c;
      bus.branch_en     = b;
      bus.branch_offset = off;
      bus.jump_target   = tgt;
   endtask

   task automatic chk_status(input string tag, input logic [31:0] pc,
                             input logic e, f, ov, uf, ack);
      chk({tag, " pc"},        bus.pc, pc);
      chk({tag, " empty"},     32'(bus.ras_empty), 32'(e));
      chk({tag, " full"},      32'(bus.ras_full), 32'(f));
      chk({tag, " overflow"},  32'(bus.ras_overflow), 32'(ov));
      chk({tag, " underflow"}, 32'(bus.ras_underflow), 32'(uf));
      chk({tag, " irq_ack"},   32'(bus.irq_ack), 32'(ack));
   endtask

   // reference model: PC as a number, RAS as a queue whose back is the top
   logic [31:0] m_pc;
   logic [31:0] m_ras [$];
   logic        m_ov, m_uf, m_ack;

   function automatic logic [31:0] model_pc_next();
      if (bus.stall)     return m_pc;
      if (bus.irq)       return 32'd16;
      if (bus.ret_en)    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : m_pc + 32'd1;
      if (bus.jump_en)   return bus.jump_target;
      if (bus.branch_en) return m_pc + 32'd1 + bus.branch_offset;
      return m_pc + 32'd1;
   endfunction

   task automatic model_push(input logic [31:0] v);
      m_ras.push_back(v);
      if (m_ras.size() > 4) begin
         void'(m_ras.pop_front());
         m_ov = 1'b1;
      end
   endtask

   task automatic model_edge();
      logic [31:0] nx;
      nx = model_pc_next();
      if (!bus.stall) begin
         if (bus.irq) model_push(m_pc);
         else if (bus.ret_en) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            else m_uf = 1'b1;
         end else if (bus.jump_en && bus.call_en) model_push(m_pc + 32'd1);
      end
      m_ack = !bus.stall && bus.irq;
      m_pc  = nx;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //      s i r j c b  off  tgt           pc            e f ov uf ack
      vt[0]  = mk(0,0,0,0,0,0, 0,  0,            1,            1,0,0,0,0);
      vt[1]  = mk(0,0,0,0,0,0, 0,  0,            2,            1,0,0,0,0);
      vt[2]  = mk(0,0,0,0,0,0, 0,  0,            3,            1,0,0,0,0);
      vt[3]  = mk(0,0,0,1,0,0, 0,  10,           10,           1,0,0,0,0);
      vt[4]  = mk(0,0,0,0,0,1, -3, 0,            8,            1,0,0,0,0);
      vt[5]  = mk(0,0,0,1,0,0, 0,  32'hFFFFFFFF, 32'hFFFFFFFF, 1,0,0,0,0);
      vt[6]  = mk(0,0,0,0,0,0, 0,  0,            0,            1,0,0,0,0);
      vt[7]  = mk(0,0,0,1,0,0, 0,  5,            5,            1,0,0,0,0);
      vt[8]  = mk(0,0,0,1,1,0, 0,  100,          100,          0,0,0,0,0);
      vt[9]  = mk(0,0,0,0,0,0, 0,  0,            101,          0,0,0,0,0);
      vt[10] = mk(0,0,0,0,0,0, 0,  0,            102,          0,0,0,0,0);
      vt[11] = mk(0,0,1,0,0,0, 0,  0,            6,            1,0,0,0,0);
      vt[12] = mk(0,0,0,1,0,0, 0,  20,           20,           1,0,0,0,0);
      vt[13] = mk(1,1,1,1,0,0, 0,  50,           20,           1,0,0,0,0);
      vt[14] = mk(0,1,1,1,0,0, 0,  50,           16,           0,0,0,0,1);
      vt[15] = mk(0,0,0,0,0,0, 0,  0,            17,           0,0,0,0,0);
      vt[16] = mk(0,0,1,0,0,0, 0,  0,            20,           1,0,0,0,0);
      vt[17] = mk(0,0,1,0,0,0, 0,  0,            21,           1,0,0,1,0);
      vt[18] = mk(0,0,0,0,1,0, 0,  0,            22,           1,0,0,1,0);
      vt[19] = mk(0,0,0,0,0,1, 10, 0,            33,           1,0,0,1,0);
      vt[20] = mk(0,0,0,1,1,0, 0,  200,          200,          0,0,0,1,0);
      vt[21] = mk(0,0,0,1,1,0, 0,  300,          300,          0,0,0,1,0);
      vt[22] = mk(0,0,0,1,1,0, 0,  400,          400,          0,0,0,1,0);
      vt[23] = mk(0,0,0,1,1,0, 0,  500,          500,          0,1,0,1,0);
      vt[24] = mk(0,0,0,1,1,0, 0,  600,          600,          0,1,1,1,0);
      vt[25] = mk(0,0,1,0,0,0, 0,  0,            501,          0,0,1,1,0);
      vt[26] = mk(0,0,1,0,0,0, 0,  0,            401,          0,0,1,1,0);
      vt[27] = mk(0,0,1,0,0,0, 0,  0,            301,          0,0,1,1,0);
      vt[28] = mk(0,0,1,0,0,0, 0,  0,            201,          1,0,1,1,0);
      vt[29] = mk(0,0,1,0,0,0, 0,  0,            202,          1,0,1,1,0);

      reset_n = 1'b0;
      drive(0,0,0,0,0,0, 0, 0);
      #12;
      chk_status("reset", 32'd0, 1, 0, 0, 0, 0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int k = 0; k < 30; k++) begin
         drive(vt[k].s, vt[k].i, vt[k].r, vt[k].j, vt[k].c, vt[k].b, vt[k].off, vt[k].tgt);
         #1;
         chk($sformatf("row%0d pc_next", k), bus.pc_next, vt[k].exp_pc);
         @(posedge clock);
         #1;
         chk_status($sformatf("row%0d", k), vt[k].exp_pc, vt[k].e, vt[k].f, vt[k].ov, vt[k].uf, vt[k].ack);
      end

      // mid-operation reset with a call pending and a non-empty RAS
      drive(0,0,0,1,1,0, 0, 40);
      @(posedge clock);
      #1;
      chk_status("pre_reset", 32'd40, 0, 0, 1, 1, 0);
      drive(0,0,0,1,1,0, 0, 77);
      #2;
      reset_n = 1'b0;
      #1;
      chk_status("mid_reset", 32'd0, 1, 0, 0, 0, 0);
      drive(0,0,0,0,0,0, 0, 0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk_status("post_reset", 32'd1, 1, 0, 0, 0, 0);

      // randomized run against the reference model
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      m_pc  = 32'd0;
      m_ras.delete();
      m_ov  = 1'b0;
      m_uf  = 1'b0;
      m_ack = 1'b0;
      chk("rand_start pc", bus.pc, m_pc);
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(7) == 0, $urandom_range(9) == 0, $urandom_range(5) == 0,
               $urandom_range(4) == 0, $urandom_range(1) == 1, $urandom_range(3) == 0,
               ($urandom_range(7) == 0) ? $urandom() : 32'(int'($urandom_range(40)) - 20),
               ($urandom_range(7) == 0) ? $urandom() : 32'($urandom_range(255)));
         #1;
         chk($sformatf("rand%0d pc_next", n), bus.pc_next, model_pc_next());
         @(posedge clock);
         #1;
         model_edge();
         chk_status($sformatf("rand%0d", n), m_pc, m_ras.size() == 0, m_ras.size() == 4,
                    m_ov, m_uf, m_ack);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
